// File: rtl/vx_cluster_mem_arb.sv
// Merges per-cluster L2 memory ports onto one memory port: round-robin request
// arbitration with source index in the tag, index-routed responses, bounded reads.
module vx_cluster_mem_arb #(
  parameter int unsigned NUM_INPUTS   = 4,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned TAG_IN_WIDTH = 8,
  parameter int unsigned MAX_PENDING  = 16
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_INPUTS-1:0]                        in_req_valid,
  input  logic [NUM_INPUTS-1:0]                        in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]             in_req_addr,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]             in_req_data,
  input  logic [NUM_INPUTS*DATA_WIDTH/8-1:0]           in_req_byteen,
  input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]           in_req_tag,
  output logic [NUM_INPUTS-1:0]                        in_req_ready,
  output logic [NUM_INPUTS-1:0]                        in_rsp_valid,
  output logic [DATA_WIDTH-1:0]                        in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]                      in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]                        in_rsp_ready,
  output logic                                         out_req_valid,
  output logic                                         out_req_rw,
  output logic [ADDR_WIDTH-1:0]                        out_req_addr,
  output logic [DATA_WIDTH-1:0]                        out_req_data,
  output logic [DATA_WIDTH/8-1:0]                      out_req_byteen,
  output logic [TAG_IN_WIDTH+$clog2(NUM_INPUTS)-1:0]   out_req_tag,
  input  logic                                         out_req_ready,
  input  logic                                         out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                        out_rsp_data,
  input  logic [TAG_IN_WIDTH+$clog2(NUM_INPUTS)-1:0]   out_rsp_tag,
  output logic                                         out_rsp_ready,
  output logic                                         busy
);

  localparam int unsigned SEL_BITS = $clog2(NUM_INPUTS);
  localparam int unsigned TAG_OUT  = TAG_IN_WIDTH + SEL_BITS;
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PEND_W   = $clog2(MAX_PENDING) + 1;
  localparam int unsigned REQ_W    = 1 + ADDR_WIDTH + DATA_WIDTH + BE_WIDTH + TAG_OUT;
  localparam int unsigned RSP_W    = DATA_WIDTH + TAG_OUT;

  logic [NUM_INPUTS-1:0] elig_c;
  logic                  grant_vld_c;
  logic [SEL_BITS-1:0]   grant_c;
  logic [SEL_BITS:0]     idx_c;
  logic [SEL_BITS-1:0]   ptr_q, ptr_d;
  logic [PEND_W-1:0]     pend_q, pend_d;
  logic                  busy_q;

  logic [REQ_W-1:0]      rq_mem_q [2];
  logic [REQ_W-1:0]      rq_entry_c;
  logic                  rq_wp_q, rq_rp_q;
  logic [1:0]            rq_cnt_q;
  logic                  rq_push_c, rq_pop_c;

  logic [RSP_W-1:0]      rs_mem_q [2];
  logic [RSP_W-1:0]      rs_head_c;
  logic [SEL_BITS-1:0]   rs_sel_c;
  logic                  rs_wp_q, rs_rp_q;
  logic [1:0]            rs_cnt_q;
  logic                  rs_push_c, rs_pop_c, rs_vld_c;

  // Round-robin search starting at the pointer; reads are held back at the pending limit.
  always_comb begin
    elig_c      = in_req_valid & (in_req_rw | {NUM_INPUTS{pend_q < PEND_W'(MAX_PENDING)}});
    grant_vld_c = 1'b0;
    grant_c     = '0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      idx_c = {1'b0, ptr_q} + (SEL_BITS+1)'(k);
      if (idx_c >= (SEL_BITS+1)'(NUM_INPUTS)) idx_c = idx_c - (SEL_BITS+1)'(NUM_INPUTS);
      if (!grant_vld_c && (rq_cnt_q != 2'd2) && elig_c[idx_c[SEL_BITS-1:0]]) begin
        grant_vld_c = 1'b1;
        grant_c     = idx_c[SEL_BITS-1:0];
      end
    end
  end

  assign in_req_ready = grant_vld_c ? (NUM_INPUTS'(1) << grant_c) : '0;
  assign rq_push_c    = grant_vld_c;
  assign rq_pop_c     = (rq_cnt_q != 2'd0) && out_req_ready;
  assign rq_entry_c   = {in_req_rw[grant_c],
                         in_req_addr[32'(grant_c)*ADDR_WIDTH +: ADDR_WIDTH],
                         in_req_data[32'(grant_c)*DATA_WIDTH +: DATA_WIDTH],
                         in_req_byteen[32'(grant_c)*BE_WIDTH +: BE_WIDTH],
                         in_req_tag[32'(grant_c)*TAG_IN_WIDTH +: TAG_IN_WIDTH],
                         grant_c};

  assign out_req_valid = (rq_cnt_q != 2'd0);
  assign {out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag} = rq_mem_q[rq_rp_q];

  // Response side: tag LSBs select the destination cluster.
  assign out_rsp_ready = (rs_cnt_q != 2'd2);
  assign rs_push_c     = out_rsp_valid && out_rsp_ready;
  assign rs_vld_c      = (rs_cnt_q != 2'd0);
  assign rs_head_c     = rs_mem_q[rs_rp_q];
  assign rs_sel_c      = rs_head_c[SEL_BITS-1:0];
  assign in_rsp_tag    = rs_head_c[TAG_OUT-1:SEL_BITS];
  assign in_rsp_data   = rs_head_c[RSP_W-1:TAG_OUT];
  assign rs_pop_c      = rs_vld_c && in_rsp_ready[rs_sel_c];

  always_comb begin
    in_rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      in_rsp_valid[i] = rs_vld_c && (rs_sel_c == SEL_BITS'(i));
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    pend_d = pend_q;
    if (grant_vld_c) begin
      ptr_d = (grant_c == SEL_BITS'(NUM_INPUTS-1)) ? '0 : grant_c + SEL_BITS'(1);
    end
    case ({rq_push_c && !in_req_rw[grant_c], rs_push_c})
      2'b10:   pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      pend_q   <= '0;
      busy_q   <= 1'b0;
      rq_wp_q  <= 1'b0;
      rq_rp_q  <= 1'b0;
      rq_cnt_q <= 2'd0;
      rs_wp_q  <= 1'b0;
      rs_rp_q  <= 1'b0;
      rs_cnt_q <= 2'd0;
    end else begin
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      busy_q   <= (pend_q != '0) || (rq_cnt_q != 2'd0) || (rs_cnt_q != 2'd0);
      rq_wp_q  <= rq_wp_q ^ rq_push_c;
      rq_rp_q  <= rq_rp_q ^ rq_pop_c;
      rq_cnt_q <= rq_cnt_q + 2'(rq_push_c) - 2'(rq_pop_c);
      rs_wp_q  <= rs_wp_q ^ rs_push_c;
      rs_rp_q  <= rs_rp_q ^ rs_pop_c;
      rs_cnt_q <= rs_cnt_q + 2'(rs_push_c) - 2'(rs_pop_c);
    end
  end

  // Payload storage needs no reset; validity lives in the counters.
  always_ff @(posedge clk) begin
    if (rq_push_c) rq_mem_q[rq_wp_q] <= rq_entry_c;
    if (rs_push_c) rs_mem_q[rs_wp_q] <= {out_rsp_data, out_rsp_tag};
  end

  assign busy = busy_q;

  a_pend_max: assert property (@(posedge clk) disable iff (!reset_n) pend_q <= PEND_W'(MAX_PENDING));
  a_pend_min: assert property (@(posedge clk) disable iff (!reset_n) rs_push_c |-> (pend_q != '0));
  a_sel_rng:  assert property (@(posedge clk) disable iff (!reset_n)
                out_rsp_valid |-> ({1'b0, out_rsp_tag[SEL_BITS-1:0]} < (SEL_BITS+1)'(NUM_INPUTS)));

endmodule

// File: tb/tb_vx_cluster_mem_arb.sv
// Directed bench for vx_cluster_mem_arb: vector table for arbitration/stall plus
// hand sequences for the pending limit, response routing and mid-operation reset.
module tb_vx_cluster_mem_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 26;
  localparam int unsigned DW = 512;
  localparam int unsigned TW = 8;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DW-1:0] in_req_data;
  logic [N*DW/8-1:0] in_req_byteen;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_rsp_valid, in_rsp_ready;
  logic [DW-1:0]   in_rsp_data;
  logic [TW-1:0]   in_rsp_tag;
  logic            out_req_valid, out_req_rw, out_req_ready;
  logic [AW-1:0]   out_req_addr;
  logic [DW-1:0]   out_req_data;
  logic [DW/8-1:0] out_req_byteen;
  logic [TW+1:0]   out_req_tag;
  logic            out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]   out_rsp_data;
  logic [TW+1:0]   out_rsp_tag;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  vx_cluster_mem_arb dut (
    .clk(clk), .reset_n(reset_n),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_data(out_req_data), .out_req_byteen(out_req_byteen), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(out_rsp_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] vld;
    logic [3:0] rw;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [3:0] vld, input logic ordy, input logic [3:0] rdy,
                              input logic ov, input logic [1:0] sel);
    vec_t v;
    v.vld = vld; v.rw = 4'b0000; v.ordy = ordy; v.exp_rdy = rdy; v.exp_ov = ov; v.exp_sel = sel;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_req_valid = '0; in_req_rw = '0; out_req_ready = 1'b1;
    out_rsp_valid = 1'b0; in_rsp_ready = '1;
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic send_rsp(input logic [7:0] tg, input logic [1:0] sel);
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {tg, sel};
    out_rsp_data  = {8{56'h0, tg}};
  endtask

  logic [9:0]  exp_tag;
  logic [25:0] exp_addr;

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      in_req_addr[i*AW +: AW]       = 26'h100 + 26'(i);
      in_req_tag[i*TW +: TW]        = 8'h10 + 8'(i);
      in_req_data[i*DW +: DW]       = {16{32'hC0DE0000 + 32'(i)}};
      in_req_byteen[i*DW/8 +: DW/8] = '1;
    end
    out_rsp_tag  = '0;
    out_rsp_data = '0;

    // Reset state
    in_req_valid = '0; in_req_rw = '0; out_req_ready = 1'b1;
    out_rsp_valid = 1'b0; in_rsp_ready = '1;
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    chk("rst_out_req_valid", 64'(out_req_valid), 64'd0);
    chk("rst_in_rsp_valid", 64'(in_rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_rsp_ready", 64'(out_rsp_ready), 64'd1);
    chk("rst_in_req_ready", 64'(in_req_ready), 64'd0);
    reset_n = 1'b1;

    // Vector table: 8 cycles all-valid, inputs 0+2 pair, then a 5-cycle stall
    for (int k = 0; k < 8; k++)
      vecs[k] = mk(4'b1111, 1'b1, 4'(1 << (k % 4)), (k > 0), 2'((k + 3) % 4));
    vecs[8]  = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3);
    vecs[9]  = mk(4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0);
    vecs[10] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd0);
    vecs[11] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2);
    vecs[12] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    vecs[13] = mk(4'b1111, 1'b0, 4'b1000, 1'b0, 2'd0);
    vecs[14] = mk(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd3);
    vecs[15] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
    vecs[16] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
    vecs[17] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
    vecs[18] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3);
    vecs[19] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0);
    vecs[20] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);

    for (int r = 0; r < 21; r++) begin
      in_req_valid  = vecs[r].vld;
      in_req_rw     = vecs[r].rw;
      out_req_ready = vecs[r].ordy;
      #1;
      chk($sformatf("v%0d_in_req_ready", r), 64'(in_req_ready), 64'(vecs[r].exp_rdy));
      chk($sformatf("v%0d_out_req_valid", r), 64'(out_req_valid), 64'(vecs[r].exp_ov));
      if (vecs[r].exp_ov) begin
        exp_tag  = {8'h10 + 8'(vecs[r].exp_sel), vecs[r].exp_sel};
        exp_addr = 26'h100 + 26'(vecs[r].exp_sel);
        chk($sformatf("v%0d_out_req_tag", r), 64'(out_req_tag), 64'(exp_tag));
        chk($sformatf("v%0d_out_req_addr", r), 64'(out_req_addr), 64'(exp_addr));
        chk($sformatf("v%0d_out_req_data", r), out_req_data[63:0],
            {2{32'hC0DE0000 + 32'(vecs[r].exp_sel)}});
      end
      next_cycle();
    end

    // Pending limit: 16 reads fill the budget, writes still pass
    do_reset();
    for (int c = 0; c < 16; c++) begin
      in_req_valid = 4'b0001; in_req_rw = 4'b0000;
      #1;
      chk($sformatf("rd%0d_in_req_ready", c), 64'(in_req_ready), 64'b0001);
      next_cycle();
    end
    in_req_valid = 4'b0011; in_req_rw = 4'b0010;
    #1;
    chk("limit_write_passes", 64'(in_req_ready), 64'b0010);
    chk("limit_busy", 64'(busy), 64'd1);
    next_cycle();
    in_req_valid = 4'b0001; in_req_rw = 4'b0000;
    send_rsp(8'h01, 2'd0);
    #1;
    chk("limit_read_stalled", 64'(in_req_ready), 64'b0000);
    chk("limit_out_rsp_ready", 64'(out_rsp_ready), 64'd1);
    next_cycle();
    out_rsp_valid = 1'b0;
    #1;
    chk("limit_read_resumes", 64'(in_req_ready), 64'b0001);
    chk("limit_in_rsp_valid", 64'(in_rsp_valid), 64'b0001);
    chk("limit_in_rsp_tag", 64'(in_rsp_tag), 64'h01);
    next_cycle();
    in_req_valid = 4'b0000;
    #1;
    chk("limit_rsp_drained", 64'(in_rsp_valid), 64'b0000);

    // Response routing and back-pressure
    in_rsp_ready = 4'b0000;
    send_rsp(8'hA5, 2'd3);
    #1;
    chk("rsp_a_out_rsp_ready", 64'(out_rsp_ready), 64'd1);
    next_cycle();
    send_rsp(8'h5A, 2'd1);
    #1;
    chk("rsp_b_in_rsp_valid", 64'(in_rsp_valid), 64'b1000);
    chk("rsp_b_in_rsp_tag", 64'(in_rsp_tag), 64'hA5);
    chk("rsp_b_in_rsp_data", in_rsp_data[63:0], 64'hA5);
    chk("rsp_b_out_rsp_ready", 64'(out_rsp_ready), 64'd1);
    next_cycle();
    send_rsp(8'h33, 2'd2);
    #1;
    chk("rsp_c_out_rsp_ready", 64'(out_rsp_ready), 64'd0);
    chk("rsp_c_in_rsp_valid", 64'(in_rsp_valid), 64'b1000);
    next_cycle();
    out_rsp_valid = 1'b0;
    in_rsp_ready  = 4'b1000;
    #1;
    chk("rsp_d_in_rsp_valid", 64'(in_rsp_valid), 64'b1000);
    chk("rsp_d_in_rsp_tag", 64'(in_rsp_tag), 64'hA5);
    next_cycle();
    in_rsp_ready = 4'b1111;
    #1;
    chk("rsp_e_in_rsp_valid", 64'(in_rsp_valid), 64'b0010);
    chk("rsp_e_in_rsp_tag", 64'(in_rsp_tag), 64'h5A);
    chk("rsp_e_out_rsp_ready", 64'(out_rsp_ready), 64'd1);
    next_cycle();
    #1;
    chk("rsp_f_in_rsp_valid", 64'(in_rsp_valid), 64'b0000);

    // Mid-operation reset with both buffers full
    out_req_ready = 1'b0; in_rsp_ready = 4'b0000;
    in_req_valid = 4'b0011; in_req_rw = 4'b0000;
    send_rsp(8'h77, 2'd0);
    next_cycle();
    send_rsp(8'h78, 2'd1);
    next_cycle();
    out_rsp_valid = 1'b0;
    #1;
    chk("full_out_req_valid", 64'(out_req_valid), 64'd1);
    chk("full_out_rsp_ready", 64'(out_rsp_ready), 64'd0);
    chk("full_in_req_ready", 64'(in_req_ready), 64'b0000);
    chk("full_busy", 64'(busy), 64'd1);
    in_req_valid = 4'b0000;
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    out_req_ready = 1'b1; in_rsp_ready = 4'b1111;
    #1;
    chk("mrst_out_req_valid", 64'(out_req_valid), 64'd0);
    chk("mrst_in_rsp_valid", 64'(in_rsp_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_out_rsp_ready", 64'(out_rsp_ready), 64'd1);
    next_cycle();
    #1;
    chk("mrst_busy_settled", 64'(busy), 64'd0);
    chk("mrst_no_stale_rsp", 64'(in_rsp_valid), 64'd0);
    in_req_valid = 4'b0100;
    #1;
    chk("mrst_ptr_zero_grant", 64'(in_req_ready), 64'b0100);
    next_cycle();
    in_req_valid = 4'b0000;
    #1;
    chk("mrst_req_out_tag", 64'(out_req_tag), 64'({8'h12, 2'd2}));
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
